// File: rtl/key_debounce_if.sv
// Key pins in, conditioned levels and pulses out, plus the per-key FSM state for observation.
// No handshake: KEY_IN is a raw level sampled every clock, and all outputs are registered levels or 1-cycle pulses.
interface key_debounce_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0]   KEY_IN;
    logic [N_KEYS-1:0]   KEY_STATE;
    logic [N_KEYS-1:0]   KEY_PRESS;
    logic [N_KEYS-1:0]   KEY_RELEASE;
    logic [N_KEYS-1:0]   KEY_HOLD;
    logic [2*N_KEYS-1:0] fsm_state;

    modport master (
        output KEY_IN,
        input  KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_HOLD, fsm_state
    );

    modport slave (
        input  KEY_IN,
        output KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_HOLD, fsm_state
    );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer and debounce FSM producing a clean level plus
// press, release and long-hold pulses.
module key_debounce #(
    parameter int N_KEYS        = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic          FPGA_CLK1_50,
    input  logic          RESET,
    key_debounce_if.slave keys
);
    localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic          REL_LVL     = (ACTIVE_LOW != 0);
    localparam logic          HOLD_EN     = (HOLD_CYCLES != 0);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_P  = 2'd1,
        PRESSED = 2'd2,
        PEND_R  = 2'd3
    } state_t;

    logic [N_KEYS-1:0]   state_v;
    logic [N_KEYS-1:0]   press_v;
    logic [N_KEYS-1:0]   release_v;
    logic [N_KEYS-1:0]   hold_v;
    logic [2*N_KEYS-1:0] dbg_v;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   p;
        state_t                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic [CW-1:0]          hcnt_q, hcnt_d;
        logic                   fired_q, fired_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;
        logic                   hold_q, hold_d;

        // Sync flops reset to the released level so reset never looks like a press.
        always_ff @(posedge FPGA_CLK1_50 or posedge RESET) begin
            if (RESET) begin
                sync_q  <= {SYNC_STAGES{REL_LVL}};
                state_q <= IDLE;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                fired_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], keys.KEY_IN[k]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hcnt_q  <= hcnt_d;
                fired_q <= fired_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                hold_q  <= hold_d;
            end
        end

        assign p = sync_q[SYNC_STAGES-1] ^ REL_LVL;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hcnt_d  = hcnt_q;
            fired_d = fired_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            hold_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (p) begin
                        state_d = PEND_P;
                        cnt_d   = '0;
                    end
                end
                PEND_P: begin
                    if (!p) begin
                        state_d = IDLE;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state_d = PEND_R;
                        cnt_d   = '0;
                    end else if (HOLD_EN && !fired_q) begin
                        // hcnt parks on its last value once the hold has fired.
                        if (hcnt_q == HOLD_LAST) begin
                            hold_d  = 1'b1;
                            fired_d = 1'b1;
                        end else begin
                            hcnt_d = hcnt_q + CW'(1);
                        end
                    end
                end
                PEND_R: begin
                    if (p) begin
                        state_d = PRESSED;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        fired_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign state_v[k]      = level_q;
        assign press_v[k]      = press_q;
        assign release_v[k]    = rel_q;
        assign hold_v[k]       = hold_q;
        assign dbg_v[2*k +: 2] = state_q;
    end

    assign keys.KEY_STATE   = state_v;
    assign keys.KEY_PRESS   = press_v;
    assign keys.KEY_RELEASE = release_v;
    assign keys.KEY_HOLD    = hold_v;
    assign keys.fsm_state   = dbg_v;
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed latency scenarios plus randomized key activity,
// all checked against a run-length model of the debounce rules.
module tb_key_debounce;
    localparam int N  = 2;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam int HC = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_debounce_if #(.N_KEYS(N)) keys ();

    key_debounce #(
        .N_KEYS(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .ACTIVE_LOW(1)
    ) dut (
        .FPGA_CLK1_50(clk),
        .RESET(rst),
        .keys(keys)
    );

    int total = 0;
    int bad   = 0;

    logic [4*N-1:0] exp_q[$];
    logic [N-1:0]   hist[$];
    logic [N-1:0]   m_lvl, m_fired;
    int             m_run[N];
    int             m_hc[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl   = '0;
        m_fired = '0;
        for (int k = 0; k < N; k++) begin
            m_run[k] = 0;
            m_hc[k]  = 0;
        end
        hist.delete();
        exp_q.delete();
        repeat (SS) hist.push_back('1);
    endtask

    // A key's level flips once SC+1 consecutive synchronized samples disagree with it;
    // hold counts steady pressed samples that do not end a release bounce.
    task automatic model_step();
        logic [N-1:0] samp, pr, rl, hd;
        logic         pressed;
        samp = hist.pop_front();
        hist.push_back(keys.KEY_IN);
        pr = '0; rl = '0; hd = '0;
        for (int k = 0; k < N; k++) begin
            pressed = !samp[k];
            if (pressed == m_lvl[k]) begin
                if (m_lvl[k] && m_run[k] == 0 && !m_fired[k]) begin
                    m_hc[k]++;
                    if (m_hc[k] == HC) begin
                        hd[k]      = 1'b1;
                        m_fired[k] = 1'b1;
                    end
                end
                m_run[k] = 0;
            end else begin
                m_run[k]++;
                if (m_run[k] == SC + 1) begin
                    m_lvl[k] = pressed;
                    m_run[k] = 0;
                    if (pressed) begin
                        pr[k]   = 1'b1;
                        m_hc[k] = 0;
                    end else begin
                        rl[k]      = 1'b1;
                        m_fired[k] = 1'b0;
                    end
                end
            end
        end
        exp_q.push_back({m_lvl, pr, rl, hd});
    endtask

    task automatic check_outputs(input logic [4*N-1:0] exp);
        check_eq("state",   keys.KEY_STATE,   exp[4*N-1:3*N]);
        check_eq("press",   keys.KEY_PRESS,   exp[3*N-1:2*N]);
        check_eq("release", keys.KEY_RELEASE, exp[2*N-1:N]);
        check_eq("hold",    keys.KEY_HOLD,    exp[N-1:0]);
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        if (rst) check_outputs('0);
        else check_outputs(exp_q.pop_front());
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_state",   keys.KEY_STATE,   0);
        check_eq("rst_press",   keys.KEY_PRESS,   0);
        check_eq("rst_release", keys.KEY_RELEASE, 0);
        check_eq("rst_hold",    keys.KEY_HOLD,    0);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic settle(input int n);
        keys.KEY_IN = '1;
        repeat (n) step();
    endtask

    int t_press, t_hold, t_rel, n_press, n_hold, n_any;
    int dur[N];

    initial begin
        rst         = 1'b1;
        keys.KEY_IN = '1;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        settle(4);

        // Clean press, long hold, then release.
        keys.KEY_IN[0] = 1'b0;
        t_press = -1; t_hold = -1; n_hold = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (keys.KEY_PRESS[0] && t_press < 0) t_press = i;
            if (keys.KEY_HOLD[0]) begin
                n_hold++;
                if (t_hold < 0) t_hold = i;
            end
            if (i == 6) check_eq("key1_idle", keys.KEY_STATE[1], 0);
        end
        check_eq("press_latency", t_press, 6);
        check_eq("hold_delay", t_hold - t_press, HC);
        check_eq("hold_count", n_hold, 1);
        keys.KEY_IN[0] = 1'b1;
        t_rel = -1; n_hold = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (keys.KEY_RELEASE[0] && t_rel < 0) t_rel = i;
            if (keys.KEY_HOLD[0]) n_hold++;
        end
        check_eq("release_latency", t_rel, 6);
        check_eq("hold_after_release", n_hold, 0);

        // Bounce: toggle every 2 cycles, then settle low.
        n_press = 0;
        for (int i = 0; i < 12; i++) begin
            keys.KEY_IN[0] = ((i / 2) % 2) != 0;
            step();
            if (keys.KEY_PRESS[0]) n_press++;
        end
        keys.KEY_IN[0] = 1'b0;
        t_press = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (keys.KEY_PRESS[0]) begin
                n_press++;
                if (t_press < 0) t_press = i;
            end
        end
        check_eq("bounce_presses", n_press, 1);
        check_eq("bounce_latency", t_press, 6);
        settle(20);

        // Glitch of 3 cycles: nothing may move.
        n_any = 0;
        keys.KEY_IN[0] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) keys.KEY_IN[0] = 1'b1;
            step();
            if ((keys.KEY_STATE | keys.KEY_PRESS | keys.KEY_RELEASE | keys.KEY_HOLD) != 0) n_any++;
        end
        check_eq("glitch_quiet", n_any, 0);

        // Both keys together, then key 1 lagging by one cycle.
        keys.KEY_IN = '0;
        t_press = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (keys.KEY_PRESS != 0 && t_press < 0) begin
                t_press = i;
                check_eq("both_press", keys.KEY_PRESS, 2'b11);
            end
        end
        check_eq("both_latency", t_press, 6);
        settle(30);
        keys.KEY_IN[0] = 1'b0;
        t_press = -1; t_rel = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) keys.KEY_IN[1] = 1'b0;
            if (keys.KEY_PRESS[0] && t_press < 0) t_press = i;
            if (keys.KEY_PRESS[1] && t_rel < 0) t_rel = i;
        end
        check_eq("lag_offset", t_rel - t_press, 1);

        // Reset while pressed, key still held afterwards.
        keys.KEY_IN = 2'b10;
        pulse_reset();
        t_press = -1; n_any = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (keys.KEY_RELEASE != 0) n_any++;
            if (keys.KEY_PRESS[0] && t_press < 0) t_press = i;
        end
        check_eq("reset_no_release", n_any, 0);
        check_eq("repress_latency", t_press, 6);
        settle(30);

        // Random key activity with occasional resets.
        for (int k = 0; k < N; k++) dur[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (dur[k] == 0) begin
                    keys.KEY_IN[k] = 1'($urandom_range(0, 1));
                    dur[k] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
                end
                dur[k]--;
            end
            if ($urandom_range(0, 799) == 0) pulse_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
